fp16_sub_seq: RTL

//  Sequential IEEE-754 half-precision subtractor: result = a - b. It is the

---
 rtl/fp16_sub_seq_if.sv | 23 ++
 rtl/fp16_sub_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fp16_sub_seq_if.sv
// Operand/result handshake bundle for the sequential half-precision subtractor.
// master = operand source / result sink, slave = the subtractor.
interface fp16_sub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf;
    logic        nan;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, nan
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, ovf, nan
    );
endinterface

// File: rtl/fp16_sub_seq.sv
// Multi-cycle IEEE-754 half-precision subtractor (a - b) with valid/ready handshake.
// Round-to-nearest-even, subnormals flushed to zero on input and output.
module fp16_sub_seq #(
    parameter int unsigned MAX_ALIGN = 14,
    parameter int unsigned EXP_BIAS  = 15
) (
    input  logic           clk,
    input  logic           rst,
    fp16_sub_seq_if.slave  bus
);

    localparam logic [5:0] ExpMax = 6'(2 * EXP_BIAS + 1);

    typedef enum logic [2:0] {
        StIdle, StUnpack, StAlign, StSub, StNorm, StRound, StDone
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_a, r_b;
    logic        r_sx, r_sy;
    logic [5:0]  r_ex;
    logic [13:0] r_mx, r_my;
    logic [4:0]  r_d;
    logic [14:0] r_sum;
    logic [15:0] r_res;
    logic        r_ovf, r_nan;

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_special, w_spec_nan, w_a_ge;
    logic [15:0] w_spec_res, w_x, w_y;
    logic [14:0] w_sum;
    logic [10:0] w_m;
    logic        w_up;
    logic [11:0] w_mr;
    logic [5:0]  w_ex_r;
    logic [15:0] w_rnd_res;
    logic        w_rnd_ovf;

    // Operand classification and special-case results (r_b already has its sign inverted).
    always_comb begin
        w_a_nan    = (&r_a[14:10]) && (|r_a[9:0]);
        w_b_nan    = (&r_b[14:10]) && (|r_b[9:0]);
        w_a_inf    = (&r_a[14:10]) && !(|r_a[9:0]);
        w_b_inf    = (&r_b[14:10]) && !(|r_b[9:0]);
        w_a_zero   = (r_a[14:10] == 5'd0);
        w_b_zero   = (r_b[14:10] == 5'd0);
        w_special  = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
        w_spec_nan = 1'b0;
        w_spec_res = r_a;
        if (w_a_nan || w_b_nan) begin
            w_spec_nan = 1'b1;
            w_spec_res = 16'h7E00;
        end else if (w_a_inf && w_b_inf) begin
            w_spec_nan = (r_a[15] != r_b[15]);
            w_spec_res = w_spec_nan ? 16'h7E00 : r_a;
        end else if (w_a_inf) begin
            w_spec_res = r_a;
        end else if (w_b_inf) begin
            w_spec_res = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {r_a[15] & r_b[15], 15'd0};
        end else if (w_a_zero) begin
            w_spec_res = r_b;
        end

        w_a_ge = (r_a[14:0] >= r_b[14:0]);
        w_x    = w_a_ge ? r_a : r_b;
        w_y    = w_a_ge ? r_b : r_a;

        w_sum = (r_sx != r_sy) ? ({1'b0, r_mx} - {1'b0, r_my})
                               : ({1'b0, r_mx} + {1'b0, r_my});

        w_m       = r_sum[13:3];
        w_up      = r_sum[2] & (r_sum[1] | r_sum[0] | w_m[0]);
        w_mr      = {1'b0, w_m} + {11'd0, w_up};
        w_ex_r    = r_ex + {5'd0, w_mr[11]};
        w_rnd_ovf = 1'b0;
        if (w_ex_r >= ExpMax) begin
            w_rnd_res = {r_sx, 5'h1F, 10'd0};
            w_rnd_ovf = 1'b1;
        end else if (!(w_mr[11] | w_mr[10])) begin
            // Hidden bit never reached: subnormal result is flushed to signed zero.
            w_rnd_res = {r_sx, 15'd0};
        end else begin
            w_rnd_res = {r_sx, w_ex_r[4:0], w_mr[11] ? 10'd0 : w_mr[9:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_next = StUnpack;
            end
            StUnpack: w_state_next = w_special ? StDone : StAlign;
            StAlign: begin
                if (r_d > 5'(MAX_ALIGN) || r_d <= 5'd1) w_state_next = StSub;
            end
            StSub:   w_state_next = (w_sum == 15'd0) ? StDone : StNorm;
            StNorm: begin
                if (r_sum[14] || r_sum[13] || r_ex <= 6'd1) w_state_next = StRound;
            end
            StRound: w_state_next = StDone;
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= 16'd0;
            r_b   <= 16'd0;
            r_sx  <= 1'b0;
            r_sy  <= 1'b0;
            r_ex  <= 6'd0;
            r_mx  <= 14'd0;
            r_my  <= 14'd0;
            r_d   <= 5'd0;
            r_sum <= 15'd0;
            r_res <= 16'd0;
            r_ovf <= 1'b0;
            r_nan <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_a <= bus.a;
                        r_b <= {~bus.b[15], bus.b[14:0]};
                    end
                end
                StUnpack: begin
                    if (w_special) begin
                        r_res <= w_spec_res;
                        r_nan <= w_spec_nan;
                        r_ovf <= 1'b0;
                    end else begin
                        r_sx <= w_x[15];
                        r_sy <= w_y[15];
                        r_ex <= {1'b0, w_x[14:10]};
                        r_mx <= {1'b1, w_x[9:0], 3'b000};
                        r_my <= {1'b1, w_y[9:0], 3'b000};
                        r_d  <= w_x[14:10] - w_y[14:10];
                    end
                end
                StAlign: begin
                    if (r_d > 5'(MAX_ALIGN)) begin
                        r_my <= {13'd0, |r_my};
                        r_d  <= 5'd0;
                    end else if (r_d != 5'd0) begin
                        r_my <= {1'b0, r_my[13:2], r_my[1] | r_my[0]};
                        r_d  <= r_d - 5'd1;
                    end
                end
                StSub: begin
                    r_sum <= w_sum;
                    if (w_sum == 15'd0) begin
                        r_res <= 16'h0000;
                        r_ovf <= 1'b0;
                        r_nan <= 1'b0;
                    end
                end
                StNorm: begin
                    if (r_sum[14]) begin
                        r_sum <= {1'b0, r_sum[14:2], r_sum[1] | r_sum[0]};
                        r_ex  <= r_ex + 6'd1;
                    end else if (!r_sum[13] && r_ex > 6'd1) begin
                        r_sum <= {r_sum[13:0], 1'b0};
                        r_ex  <= r_ex - 6'd1;
                    end
                end
                StRound: begin
                    r_res <= w_rnd_res;
                    r_ovf <= w_rnd_ovf;
                    r_nan <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_res;
    assign bus.ovf    = r_ovf;
    assign bus.nan    = r_nan;

endmodule
